// File: rtl/mem_arbiter_ctrl.sv
// Byte-serial RAM/IO port arbiter between instruction fetch and the load/store buffer.
// Optional MEMCTRL_RR_EN selects round-robin arbitration instead of fixed LSB-over-IF priority.
module mem_arbiter_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE = 32'h30000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush_in,
  input  logic                  if_req_in,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
  output logic                  if_done_out,
  output logic [31:0]           if_data_out,
  input  logic                  lsb_req_in,
  input  logic                  lsb_wr_in,
  input  logic [1:0]            lsb_size_in,
  input  logic [ADDR_WIDTH-1:0] lsb_addr_in,
  input  logic [31:0]           lsb_wdata_in,
  output logic                  lsb_done_out,
  output logic [31:0]           lsb_rdata_out,
  input  logic [7:0]            mem_din_in,
  output logic [7:0]            mem_dout_out,
  output logic [ADDR_WIDTH-1:0] mem_a_out,
  output logic                  mem_wr_out,
  input  logic                  io_buffer_full_in
);

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_nx;
  logic [2:0]              len_q, len_nx, cnt_q, cnt_nx;
  logic [31:0]             wdata_q, wdata_nx, buf_q, buf_nx, cap;
  logic [31:0]             if_data_nx, lsb_rdata_nx;
  logic                    io_q, io_nx;
  logic                    if_done_q, if_done_nx, lsb_done_q, lsb_done_nx;
  logic                    if_ok, lsb_ok, pick_lsb, pick_if, go_lsb, go_if;
  logic [2:0]              req_len;
  logic [1:0]              cap_idx;

  // A requester whose done pulse is showing is still holding req; ignore it this cycle.
  assign if_ok  = if_req_in & ~if_done_q;
  assign lsb_ok = lsb_req_in & ~lsb_done_q;

`ifdef MEMCTRL_RR_EN
  logic prio_lsb;
  assign pick_lsb = lsb_ok & (~if_ok | prio_lsb);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      prio_lsb <= 1'b1;
    end else if (rdy_in) begin
      if (go_lsb)     prio_lsb <= 1'b0;
      else if (go_if) prio_lsb <= 1'b1;
    end
  end
`else
  assign pick_lsb = lsb_ok;
`endif

  assign pick_if = if_ok & ~pick_lsb;
  assign go_lsb  = (state == IDLE) & rdy_in & ~flush_in & pick_lsb;
  assign go_if   = (state == IDLE) & rdy_in & ~flush_in & pick_if;

  assign if_done_out  = if_done_q & rdy_in;
  assign lsb_done_out = lsb_done_q & rdy_in;

  always_comb begin
    case (lsb_size_in)
      2'd0:    req_len = 3'd1;
      2'd1:    req_len = 3'd2;
      default: req_len = 3'd4;
    endcase
  end

  // Byte arriving this cycle belongs to the address issued one cycle earlier.
  assign cap_idx = cnt_q[1:0] - 2'd1;
  always_comb begin
    cap = buf_q;
    cap[{cap_idx, 3'b000} +: 8] = mem_din_in;
  end

  always_comb begin
    state_nx     = state;
    addr_nx      = addr_q;
    len_nx       = len_q;
    cnt_nx       = cnt_q;
    wdata_nx     = wdata_q;
    buf_nx       = buf_q;
    io_nx        = io_q;
    if_done_nx   = 1'b0;
    lsb_done_nx  = 1'b0;
    if_data_nx   = if_data_out;
    lsb_rdata_nx = lsb_rdata_out;
    mem_a_out    = '0;
    mem_wr_out   = 1'b0;
    mem_dout_out = '0;
    case (state)
      IDLE: begin
        if (go_lsb) begin
          addr_nx   = lsb_addr_in;
          len_nx    = req_len;
          wdata_nx  = lsb_wdata_in;
          io_nx     = (lsb_addr_in >= IO_BASE);
          buf_nx    = '0;
          mem_a_out = lsb_addr_in;
          if (!lsb_wr_in) begin
            state_nx = LS_RD;
            cnt_nx   = 3'd1;
          end else if ((lsb_addr_in >= IO_BASE) && io_buffer_full_in) begin
            state_nx = LS_WR;
            cnt_nx   = 3'd0;
          end else begin
            mem_wr_out   = 1'b1;
            mem_dout_out = lsb_wdata_in[7:0];
            if (req_len == 3'd1) begin
              lsb_done_nx = 1'b1;
            end else begin
              state_nx = LS_WR;
              cnt_nx   = 3'd1;
            end
          end
        end else if (go_if) begin
          addr_nx   = if_addr_in;
          len_nx    = 3'd4;
          buf_nx    = '0;
          mem_a_out = if_addr_in;
          state_nx  = IF_RD;
          cnt_nx    = 3'd1;
        end
      end
      IF_RD, LS_RD: begin
        // While frozen, keep pointing at the last issued byte so it is still on mem_din at resume.
        if (!rdy_in) begin
          mem_a_out = addr_q + ADDR_WIDTH'(cnt_q) - ADDR_WIDTH'(1);
        end else if (flush_in) begin
          state_nx = IDLE;
          cnt_nx   = 3'd0;
        end else begin
          buf_nx = cap;
          if (cnt_q == len_q) begin
            state_nx = IDLE;
            cnt_nx   = 3'd0;
            if (state == IF_RD) begin
              if_done_nx = 1'b1;
              if_data_nx = cap;
            end else begin
              lsb_done_nx  = 1'b1;
              lsb_rdata_nx = cap;
            end
          end else begin
            mem_a_out = addr_q + ADDR_WIDTH'(cnt_q);
            cnt_nx    = cnt_q + 3'd1;
          end
        end
      end
      LS_WR: begin
        mem_a_out = addr_q + ADDR_WIDTH'(cnt_q);
        if (rdy_in && !(io_q && io_buffer_full_in)) begin
          mem_wr_out   = 1'b1;
          mem_dout_out = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          cnt_nx       = cnt_q + 3'd1;
          if ((cnt_q + 3'd1) == len_q) begin
            state_nx    = IDLE;
            cnt_nx      = 3'd0;
            lsb_done_nx = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      addr_q        <= '0;
      len_q         <= 3'd0;
      cnt_q         <= 3'd0;
      wdata_q       <= '0;
      buf_q         <= '0;
      io_q          <= 1'b0;
      if_done_q     <= 1'b0;
      lsb_done_q    <= 1'b0;
      if_data_out   <= '0;
      lsb_rdata_out <= '0;
    end else if (rdy_in) begin
      state         <= state_nx;
      addr_q        <= addr_nx;
      len_q         <= len_nx;
      cnt_q         <= cnt_nx;
      wdata_q       <= wdata_nx;
      buf_q         <= buf_nx;
      io_q          <= io_nx;
      if_done_q     <= if_done_nx;
      lsb_done_q    <= lsb_done_nx;
      if_data_out   <= if_data_nx;
      lsb_rdata_out <= lsb_rdata_nx;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed bench for mem_arbiter_ctrl with a 1-cycle-latency byte RAM model.
module tb_mem_arbiter_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in;
  logic        if_req_in, if_done_out;
  logic [31:0] if_addr_in, if_data_out;
  logic        lsb_req_in, lsb_wr_in, lsb_done_out;
  logic [1:0]  lsb_size_in;
  logic [31:0] lsb_addr_in, lsb_wdata_in, lsb_rdata_out;
  logic [7:0]  mem_din_in, mem_dout_out;
  logic [31:0] mem_a_out;
  logic        mem_wr_out, io_buffer_full_in;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] ram [0:65535];

  mem_arbiter_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_done_out(if_done_out),
    .if_data_out(if_data_out), .lsb_req_in(lsb_req_in), .lsb_wr_in(lsb_wr_in),
    .lsb_size_in(lsb_size_in), .lsb_addr_in(lsb_addr_in), .lsb_wdata_in(lsb_wdata_in),
    .lsb_done_out(lsb_done_out), .lsb_rdata_out(lsb_rdata_out), .mem_din_in(mem_din_in),
    .mem_dout_out(mem_dout_out), .mem_a_out(mem_a_out), .mem_wr_out(mem_wr_out),
    .io_buffer_full_in(io_buffer_full_in)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    mem_din_in <= ram[mem_a_out[15:0]];
    if (mem_wr_out) ram[mem_a_out[15:0]] <= mem_dout_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk_in);
  endtask

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
    if_req_in = 1'b0; if_addr_in = '0;
    lsb_req_in = 1'b0; lsb_wr_in = 1'b0; lsb_size_in = 2'd0;
    lsb_addr_in = '0; lsb_wdata_in = '0; io_buffer_full_in = 1'b0;
    mem_din_in = '0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h05; ram[16'h1002] = 8'h00; ram[16'h1003] = 8'h00;
    ram[16'h1004] = 8'h93; ram[16'h1005] = 8'h00; ram[16'h1006] = 8'h10; ram[16'h1007] = 8'h00;
    ram[16'h2000] = 8'h11; ram[16'h2001] = 8'h22; ram[16'h2002] = 8'h33; ram[16'h2003] = 8'h44;
    ram[16'h2004] = 8'h55; ram[16'h2005] = 8'h66; ram[16'h2006] = 8'h77; ram[16'h2007] = 8'h88;

    nc(); nc(); #1;
    chk("rst_mem_a", mem_a_out, 32'h0);
    chk("rst_mem_wr", {31'b0, mem_wr_out}, 32'h0);
    chk("rst_if_done", {31'b0, if_done_out}, 32'h0);
    chk("rst_lsb_done", {31'b0, lsb_done_out}, 32'h0);
    chk("rst_if_data", if_data_out, 32'h0);
    chk("rst_lsb_rdata", lsb_rdata_out, 32'h0);
    nc(); rst_in = 1'b1;
    nc(); #1;
    chk("idle_mem_a", mem_a_out, 32'h0);

    // IF fetch of 4 bytes
    nc(); if_req_in = 1'b1; if_addr_in = 32'h1000; #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin nc(); #1; end
      chk("if_addr", mem_a_out, 32'h1000 + k);
      chk("if_wr", {31'b0, mem_wr_out}, 32'h0);
    end
    nc(); #1; chk("if_done_c4", {31'b0, if_done_out}, 32'h0);
    nc(); #1;
    chk("if_done_c5", {31'b0, if_done_out}, 32'h1);
    chk("if_data", if_data_out, 32'h0000_0513);
    chk("if_no_regrant", mem_a_out, 32'h0);
    nc(); if_req_in = 1'b0; #1;
    chk("if_done_c6", {31'b0, if_done_out}, 32'h0);

    // 2-byte store
    nc(); lsb_req_in = 1'b1; lsb_wr_in = 1'b1; lsb_size_in = 2'd1;
    lsb_addr_in = 32'h2002; lsb_wdata_in = 32'h0000_BEEF; #1;
    chk("st2_wr_c0", {31'b0, mem_wr_out}, 32'h1);
    chk("st2_a_c0", mem_a_out, 32'h2002);
    chk("st2_d_c0", {24'b0, mem_dout_out}, 32'hEF);
    nc(); #1;
    chk("st2_wr_c1", {31'b0, mem_wr_out}, 32'h1);
    chk("st2_a_c1", mem_a_out, 32'h2003);
    chk("st2_d_c1", {24'b0, mem_dout_out}, 32'hBE);
    chk("st2_done_c1", {31'b0, lsb_done_out}, 32'h0);
    nc(); #1;
    chk("st2_done_c2", {31'b0, lsb_done_out}, 32'h1);
    chk("st2_wr_c2", {31'b0, mem_wr_out}, 32'h0);
    nc(); lsb_req_in = 1'b0; #1;
    chk("st2_ram_lo", {24'b0, ram[16'h2002]}, 32'hEF);
    chk("st2_ram_hi", {24'b0, ram[16'h2003]}, 32'hBE);

    // Contention: LSB 4-byte load wins, IF follows in the LSB done cycle
    nc(); if_req_in = 1'b1; if_addr_in = 32'h1004;
    lsb_req_in = 1'b1; lsb_wr_in = 1'b0; lsb_size_in = 2'd2; lsb_addr_in = 32'h2000; #1;
    chk("arb_first", mem_a_out, 32'h2000);
    // bytes 0x2002/0x2003 were overwritten by the store above
    nc(); nc(); nc(); nc(); nc(); #1;
    chk("arb_lsb_done", {31'b0, lsb_done_out}, 32'h1);
    chk("arb_lsb_data", lsb_rdata_out, 32'hBEEF_2211);
    chk("arb_if_grant", mem_a_out, 32'h1004);
    nc(); lsb_req_in = 1'b0; #1;
    chk("arb_if_a1", mem_a_out, 32'h1005);
    nc(); nc(); nc(); #1;
    chk("arb_if_done_c9", {31'b0, if_done_out}, 32'h0);
    nc(); #1;
    chk("arb_if_done_c10", {31'b0, if_done_out}, 32'h1);
    chk("arb_if_data", if_data_out, 32'h0010_0093);
    nc(); if_req_in = 1'b0;

    // IO store stalled by a full HCI buffer
    nc(); lsb_req_in = 1'b1; lsb_wr_in = 1'b1; lsb_size_in = 2'd0;
    lsb_addr_in = 32'h30000; lsb_wdata_in = 32'h0000_0041; io_buffer_full_in = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin nc(); #1; end
      chk("io_stall_wr", {31'b0, mem_wr_out}, 32'h0);
      chk("io_stall_done", {31'b0, lsb_done_out}, 32'h0);
    end
    nc(); io_buffer_full_in = 1'b0; #1;
    chk("io_wr", {31'b0, mem_wr_out}, 32'h1);
    chk("io_a", mem_a_out, 32'h30000);
    chk("io_d", {24'b0, mem_dout_out}, 32'h41);
    nc(); #1;
    chk("io_done", {31'b0, lsb_done_out}, 32'h1);
    chk("io_wr_after", {31'b0, mem_wr_out}, 32'h0);
    nc(); lsb_req_in = 1'b0;

    // IF read aborted by flush in cycle 2
    nc(); if_req_in = 1'b1; if_addr_in = 32'h1000; #1;
    chk("fl_if_a0", mem_a_out, 32'h1000);
    nc();
    nc(); flush_in = 1'b1; if_req_in = 1'b0; #1;
    chk("fl_if_wr", {31'b0, mem_wr_out}, 32'h0);
    nc(); flush_in = 1'b0; #1;
    chk("fl_if_idle", mem_a_out, 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk("fl_if_nodone", {31'b0, if_done_out}, 32'h0);
      nc(); #1;
    end

    // 4-byte store survives a flush in cycle 1
    nc(); lsb_req_in = 1'b1; lsb_wr_in = 1'b1; lsb_size_in = 2'd2;
    lsb_addr_in = 32'h2100; lsb_wdata_in = 32'hCAFE_F00D; #1;
    chk("fl_st_a0", mem_a_out, 32'h2100);
    nc(); flush_in = 1'b1; #1;
    chk("fl_st_wr1", {31'b0, mem_wr_out}, 32'h1);
    chk("fl_st_d1", {24'b0, mem_dout_out}, 32'hF0);
    nc(); flush_in = 1'b0; #1;
    chk("fl_st_a2", mem_a_out, 32'h2102);
    chk("fl_st_d2", {24'b0, mem_dout_out}, 32'hFE);
    nc(); #1;
    chk("fl_st_d3", {24'b0, mem_dout_out}, 32'hCA);
    nc(); #1;
    chk("fl_st_done", {31'b0, lsb_done_out}, 32'h1);
    nc(); lsb_req_in = 1'b0; #1;
    chk("fl_st_ram", {ram[16'h2103], ram[16'h2102], ram[16'h2101], ram[16'h2100]}, 32'hCAFE_F00D);

    // rdy_in low for two cycles in the middle of a 4-byte load
    nc(); lsb_req_in = 1'b1; lsb_wr_in = 1'b0; lsb_size_in = 2'd2; lsb_addr_in = 32'h2004; #1;
    chk("rdy_a0", mem_a_out, 32'h2004);
    nc(); #1; chk("rdy_a1", mem_a_out, 32'h2005);
    nc(); rdy_in = 1'b0; #1;
    chk("rdy_stall_wr", {31'b0, mem_wr_out}, 32'h0);
    chk("rdy_stall_done", {31'b0, lsb_done_out}, 32'h0);
    nc(); #1;
    chk("rdy_stall_wr2", {31'b0, mem_wr_out}, 32'h0);
    nc(); rdy_in = 1'b1; #1;
    chk("rdy_resume_a", mem_a_out, 32'h2006);
    nc(); #1; chk("rdy_a3", mem_a_out, 32'h2007);
    nc(); #1; chk("rdy_done_c6", {31'b0, lsb_done_out}, 32'h0);
    nc(); #1;
    chk("rdy_done_c7", {31'b0, lsb_done_out}, 32'h1);
    chk("rdy_data", lsb_rdata_out, 32'h8877_6655);
    nc(); lsb_req_in = 1'b0;

    // 1-byte load, zero-extended, done in cycle 2
    nc(); lsb_req_in = 1'b1; lsb_wr_in = 1'b0; lsb_size_in = 2'd0; lsb_addr_in = 32'h2007; #1;
    chk("ld1_a0", mem_a_out, 32'h2007);
    nc(); #1; chk("ld1_done_c1", {31'b0, lsb_done_out}, 32'h0);
    nc(); #1;
    chk("ld1_done_c2", {31'b0, lsb_done_out}, 32'h1);
    chk("ld1_data", lsb_rdata_out, 32'h0000_0088);
    nc(); lsb_req_in = 1'b0;
    nc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
